// File: rtl/dds_cmd_dispatch.sv
// Command dispatcher: buffers (addr, cmd) pairs in a 4-entry FIFO and issues them one at a time
// as req/ack writes on the DDS control bus, with an ack timeout and a mandatory inter-write gap.
module dds_cmd_dispatch #(
  parameter int unsigned            ADDR_WIDTH = 8,
  parameter int unsigned            CMD_WIDTH  = 8,
  parameter logic [ADDR_WIDTH-1:0]  MAX_ADDR   = 8'h3F,
  parameter int unsigned            TIMEOUT    = 1024,
  parameter int unsigned            GAP_CYCLES = 4
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic [ADDR_WIDTH-1:0] addr_data,
  input  logic [CMD_WIDTH-1:0]  cmd_data,
  input  logic                  cmd_data_valid,
  output logic                  wr_req,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [CMD_WIDTH-1:0]  wr_data,
  input  logic                  wr_ack,
  output logic                  busy,
  output logic [2:0]            fifo_level,
  output logic                  err_ovf,
  output logic                  err_addr,
  output logic                  err_timeout,
  output logic [7:0]            err_cnt
);

  localparam int unsigned GAP_EFF = (GAP_CYCLES == 0) ? 1 : GAP_CYCLES;
  localparam int unsigned TMR_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned GAP_W   = (GAP_EFF > 1) ? $clog2(GAP_EFF) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_EFF - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_GAP
  } state_t;

  state_t state, state_d;

  logic [ADDR_WIDTH-1:0] mem_addr [4];
  logic [CMD_WIDTH-1:0]  mem_cmd  [4];
  logic [1:0]            wr_ptr, rd_ptr;
  logic [TMR_W-1:0]      tmr, tmr_d;
  logic [GAP_W-1:0]      gap_cnt, gap_d;
  logic                  req_d;
  logic                  pop, push, addr_bad, ovf, timeout_hit;
  logic                  fifo_full, fifo_empty;

  always_comb begin
    fifo_full   = (fifo_level == 3'd4);
    fifo_empty  = (fifo_level == 3'd0);
    state_d     = state;
    tmr_d       = tmr;
    gap_d       = gap_cnt;
    req_d       = wr_req;
    pop         = 1'b0;
    timeout_hit = 1'b0;

    case (state)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          req_d   = 1'b1;
          tmr_d   = '0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        // An ack arriving on the final timer cycle still wins over the timeout.
        if (wr_ack) begin
          req_d   = 1'b0;
          gap_d   = '0;
          state_d = S_GAP;
        end else if (tmr == TMR_LAST) begin
          req_d       = 1'b0;
          timeout_hit = 1'b1;
          gap_d       = '0;
          state_d     = S_GAP;
        end else begin
          tmr_d = tmr + TMR_W'(1);
        end
      end
      S_GAP: begin
        if (gap_cnt == GAP_LAST) state_d = S_IDLE;
        else                     gap_d   = gap_cnt + GAP_W'(1);
      end
      default: state_d = S_IDLE;
    endcase

    addr_bad = cmd_data_valid && (addr_data > MAX_ADDR);
    // A pop in the same cycle frees the slot, so a push into a full FIFO is still taken.
    push     = cmd_data_valid && !addr_bad && (!fifo_full || pop);
    ovf      = cmd_data_valid && !addr_bad && fifo_full && !pop;
    busy     = !fifo_empty || (state != S_IDLE);
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state <= S_IDLE;
    else            state <= state_d;
  end

  always_ff @(posedge sys_clk) begin
    if (push) begin
      mem_addr[wr_ptr] <= addr_data;
      mem_cmd[wr_ptr]  <= cmd_data;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      wr_req      <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      tmr         <= '0;
      gap_cnt     <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_level  <= '0;
      err_ovf     <= 1'b0;
      err_addr    <= 1'b0;
      err_timeout <= 1'b0;
      err_cnt     <= '0;
    end else begin
      wr_req  <= req_d;
      tmr     <= tmr_d;
      gap_cnt <= gap_d;
      if (pop) begin
        wr_addr <= mem_addr[rd_ptr];
        wr_data <= mem_cmd[rd_ptr];
        rd_ptr  <= rd_ptr + 2'd1;
      end
      if (push) wr_ptr <= wr_ptr + 2'd1;
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + 3'd1;
        2'b01:   fifo_level <= fifo_level - 3'd1;
        default: fifo_level <= fifo_level;
      endcase
      err_ovf     <= ovf;
      err_addr    <= addr_bad;
      err_timeout <= timeout_hit;
      if ((err_ovf || err_addr || err_timeout) && (err_cnt != 8'hFF))
        err_cnt <= err_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_dds_cmd_dispatch.sv
// Bench for dds_cmd_dispatch: a cycle table from reset, hand-written corner sequences,
// and a randomized run compared against a queue-based behavioural model.
module tb_dds_cmd_dispatch;

  localparam int unsigned TIMEOUT = 1024;
  localparam int unsigned GAP     = 4;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n;
  logic [7:0] addr, cmd;
  logic       valid, ack;
  logic       wr_req, busy, err_ovf, err_addr, err_timeout;
  logic [7:0] wr_addr, wr_data, err_cnt;
  logic [2:0] fifo_level;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int last_fall   = 0;

  dds_cmd_dispatch #(
    .ADDR_WIDTH(8), .CMD_WIDTH(8), .MAX_ADDR(8'h3F), .TIMEOUT(TIMEOUT), .GAP_CYCLES(GAP)
  ) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .addr_data(addr), .cmd_data(cmd), .cmd_data_valid(valid),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(ack),
    .busy(busy), .fifo_level(fifo_level),
    .err_ovf(err_ovf), .err_addr(err_addr), .err_timeout(err_timeout), .err_cnt(err_cnt)
  );

  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_req"},  wr_req, 0);
    chk({tag, "_addr"}, wr_addr, 0);
    chk({tag, "_data"}, wr_data, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_lvl"},  fifo_level, 0);
    chk({tag, "_eovf"}, err_ovf, 0);
    chk({tag, "_eadr"}, err_addr, 0);
    chk({tag, "_etmo"}, err_timeout, 0);
    chk({tag, "_ecnt"}, err_cnt, 0);
  endtask

  task automatic apply_reset();
    sys_rst_n = 1'b0; valid = 1'b0; addr = '0; cmd = '0; ack = 1'b0;
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk) sys_rst_n = 1'b1;
    @(posedge sys_clk); #1;
  endtask

  task automatic step();
    @(posedge sys_clk); #1;
  endtask

  // Wait for a write, check its payload and (optionally) the low time before it, then ack after d cycles.
  task automatic serve(input logic [7:0] ea, input logic [7:0] ed, input int d, input bit chk_gap);
    int n = 0;
    int rise;
    @(negedge sys_clk);
    while (!wr_req && n < 200) begin n++; @(negedge sys_clk); end
    chk($sformatf("serve_req_%02h", ea), wr_req, 1);
    if (!wr_req) return;
    rise = cyc;
    chk($sformatf("serve_addr_%02h", ea), wr_addr, ea);
    chk($sformatf("serve_data_%02h", ea), wr_data, ed);
    if (chk_gap) chk($sformatf("serve_gap_%02h", ea), rise - last_fall, GAP + 1);
    repeat (d) step();
    ack = 1'b1;
    step();
    ack = 1'b0;
    last_fall = cyc;
  endtask

  typedef struct {
    logic       v;
    logic [7:0] a, c;
    logic       ack;
    logic       req;
    logic [7:0] wa, wd;
    int         lvl;
    logic       busy, ea;
    int         cnt;
  } vec_t;

  function automatic vec_t mk(logic v, logic [7:0] a, logic [7:0] c, logic k, logic req,
                              logic [7:0] wa, logic [7:0] wd, int lvl, logic b, logic ea, int cnt);
    vec_t r;
    r.v = v; r.a = a; r.c = c; r.ack = k; r.req = req; r.wa = wa; r.wd = wd;
    r.lvl = lvl; r.busy = b; r.ea = ea; r.cnt = cnt;
    return r;
  endfunction

  vec_t tv [17];

  // Behavioural model state
  logic [15:0] mq [$];
  logic        m_req, m_ea, m_eo, m_et;
  logic [7:0]  m_addr, m_data;
  int          m_age, m_gap, m_cnt;

  task automatic model_step(input logic v, input logic [7:0] a, input logic [7:0] c, input logic k);
    bit pop_now, full, any, legal;
    pop_now = !m_req && (m_gap == 0) && (mq.size() > 0);
    full    = (mq.size() == 4);
    any     = m_ea || m_eo || m_et;
    legal   = (a <= 8'h3F);
    m_ea    = v && !legal;
    m_eo    = v && legal && full && !pop_now;
    m_et    = m_req && !k && (m_age == TIMEOUT - 1);
    if (m_req) begin
      if (k || m_age == TIMEOUT - 1) begin m_req = 1'b0; m_gap = GAP; end
      else m_age++;
    end else if (m_gap > 0) begin
      m_gap--;
    end else if (pop_now) begin
      {m_addr, m_data} = mq.pop_front();
      m_req = 1'b1;
      m_age = 0;
    end
    if (v && legal && !(full && !pop_now)) mq.push_back({a, c});
    if (any && m_cnt != 255) m_cnt++;
  endtask

  initial begin
    // v a c ack | req wa wd lvl busy err_addr err_cnt
    tv[0]  = mk(1, 8'h10, 8'hA5, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0);
    tv[1]  = mk(0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 1, 1, 0, 0);
    tv[2]  = mk(0, 8'h00, 8'h00, 0, 1, 8'h10, 8'hA5, 0, 1, 0, 0);
    tv[3]  = mk(0, 8'h00, 8'h00, 0, 1, 8'h10, 8'hA5, 0, 1, 0, 0);
    tv[4]  = mk(0, 8'h00, 8'h00, 0, 1, 8'h10, 8'hA5, 0, 1, 0, 0);
    tv[5]  = mk(0, 8'h00, 8'h00, 1, 1, 8'h10, 8'hA5, 0, 1, 0, 0);
    tv[6]  = mk(0, 8'h00, 8'h00, 0, 0, 8'h10, 8'hA5, 0, 1, 0, 0);
    tv[7]  = mk(0, 8'h00, 8'h00, 0, 0, 8'h10, 8'hA5, 0, 1, 0, 0);
    tv[8]  = mk(0, 8'h00, 8'h00, 0, 0, 8'h10, 8'hA5, 0, 1, 0, 0);
    tv[9]  = mk(0, 8'h00, 8'h00, 0, 0, 8'h10, 8'hA5, 0, 1, 0, 0);
    tv[10] = mk(1, 8'h40, 8'h77, 0, 0, 8'h10, 8'hA5, 0, 0, 0, 0);
    tv[11] = mk(0, 8'h00, 8'h00, 0, 0, 8'h10, 8'hA5, 0, 0, 1, 0);
    tv[12] = mk(0, 8'h00, 8'h00, 0, 0, 8'h10, 8'hA5, 0, 0, 0, 1);
    tv[13] = mk(1, 8'h3F, 8'h01, 0, 0, 8'h10, 8'hA5, 0, 0, 0, 1);
    tv[14] = mk(0, 8'h00, 8'h00, 0, 0, 8'h10, 8'hA5, 1, 1, 0, 1);
    tv[15] = mk(0, 8'h00, 8'h00, 1, 1, 8'h3F, 8'h01, 0, 1, 0, 1);
    tv[16] = mk(0, 8'h00, 8'h00, 0, 0, 8'h3F, 8'h01, 0, 1, 0, 1);

    sys_rst_n = 1'b0; valid = 1'b0; addr = '0; cmd = '0; ack = 1'b0;
    #12;
    check_all_zero("reset");

    // Single write, bad address, boundary address
    apply_reset();
    for (int i = 0; i < 17; i++) begin
      valid = tv[i].v; addr = tv[i].a; cmd = tv[i].c; ack = tv[i].ack;
      @(negedge sys_clk);
      chk($sformatf("t%0d_req", i),  wr_req, tv[i].req);
      chk($sformatf("t%0d_addr", i), wr_addr, tv[i].wa);
      chk($sformatf("t%0d_data", i), wr_data, tv[i].wd);
      chk($sformatf("t%0d_lvl", i),  fifo_level, tv[i].lvl);
      chk($sformatf("t%0d_busy", i), busy, tv[i].busy);
      chk($sformatf("t%0d_eadr", i), err_addr, tv[i].ea);
      chk($sformatf("t%0d_eovf", i), err_ovf, 0);
      chk($sformatf("t%0d_etmo", i), err_timeout, 0);
      chk($sformatf("t%0d_ecnt", i), err_cnt, tv[i].cnt);
      step();
    end
    valid = 1'b0; ack = 1'b0;

    // Overflow: six back-to-back pushes while the first write stalls
    apply_reset();
    for (int i = 0; i < 6; i++) begin
      valid = 1'b1; addr = 8'(i + 1); cmd = 8'(8'hC0 + i);
      step();
    end
    valid = 1'b0;
    @(negedge sys_clk);
    chk("ovf_pulse", err_ovf, 1);
    chk("ovf_level", fifo_level, 4);
    chk("ovf_req", wr_req, 1);
    chk("ovf_first_addr", wr_addr, 1);
    @(negedge sys_clk);
    chk("ovf_pulse_end", err_ovf, 0);
    chk("ovf_cnt", err_cnt, 1);
    for (int i = 0; i < 5; i++) serve(8'(i + 1), 8'(8'hC0 + i), 2, i > 0);
    repeat (8) step();
    @(negedge sys_clk);
    chk("ovf_drained_busy", busy, 0);
    chk("ovf_drained_cnt", err_cnt, 1);

    // Timeout followed by the next entry after the gap
    apply_reset();
    valid = 1'b1; addr = 8'h05; cmd = 8'h11; step();
    addr = 8'h06; cmd = 8'h22; step();
    valid = 1'b0;
    begin
      int n = 0;
      @(negedge sys_clk);
      while (!wr_req && n < 50) begin n++; @(negedge sys_clk); end
      chk("tmo_req_rise", wr_req, 1);
      chk("tmo_addr", wr_addr, 8'h05);
      n = 0;
      while (wr_req && n < 1100) begin n++; @(negedge sys_clk); end
      chk("tmo_len", n, TIMEOUT);
      chk("tmo_pulse", err_timeout, 1);
      last_fall = cyc;
      @(negedge sys_clk);
      chk("tmo_pulse_end", err_timeout, 0);
    end
    serve(8'h06, 8'h22, 1, 1);
    @(negedge sys_clk);
    chk("tmo_cnt", err_cnt, 1);

    // Push into a full FIFO on the cycle the dispatcher pops
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      valid = 1'b1; addr = 8'(8'h20 + i); cmd = 8'(8'h50 + i);
      step();
    end
    valid = 1'b0;
    @(negedge sys_clk);
    chk("fp_level_full", fifo_level, 4);
    chk("fp_req", wr_req, 1);
    ack = 1'b1;
    step();
    ack = 1'b0;
    repeat (4) step();
    valid = 1'b1; addr = 8'h2A; cmd = 8'h5A;
    @(negedge sys_clk);
    chk("fp_level_at_pop", fifo_level, 4);
    chk("fp_idle_req", wr_req, 0);
    step();
    valid = 1'b0;
    @(negedge sys_clk);
    chk("fp_level_after", fifo_level, 4);
    chk("fp_no_ovf", err_ovf, 0);
    chk("fp_req_next", wr_req, 1);
    chk("fp_addr_next", wr_addr, 8'h21);
    serve(8'h21, 8'h51, 1, 0);
    serve(8'h22, 8'h52, 1, 1);
    serve(8'h23, 8'h53, 1, 1);
    serve(8'h24, 8'h54, 1, 1);
    serve(8'h2A, 8'h5A, 1, 1);
    @(negedge sys_clk);
    chk("fp_cnt", err_cnt, 0);

    // Asynchronous reset in the middle of a write with entries buffered
    apply_reset();
    valid = 1'b1; addr = 8'h50; cmd = 8'h00; step();
    for (int i = 0; i < 4; i++) begin
      addr = 8'(8'h30 + i); cmd = 8'(8'h90 + i);
      step();
    end
    valid = 1'b0;
    @(negedge sys_clk);
    chk("rst_pre_req", wr_req, 1);
    chk("rst_pre_level", fifo_level, 3);
    chk("rst_pre_cnt", err_cnt, 1);
    #2 sys_rst_n = 1'b0;
    #1 check_all_zero("rst_mid");
    repeat (2) @(posedge sys_clk);
    @(negedge sys_clk) sys_rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge sys_clk);
      chk($sformatf("rst_post%0d_busy", i), busy, 0);
      chk($sformatf("rst_post%0d_lvl", i), fifo_level, 0);
      chk($sformatf("rst_post%0d_req", i), wr_req, 0);
    end

    // Randomized traffic against the behavioural model
    apply_reset();
    mq.delete();
    m_req = 0; m_ea = 0; m_eo = 0; m_et = 0; m_addr = '0; m_data = '0;
    m_age = 0; m_gap = 0; m_cnt = 0;
    for (int i = 0; i < 4000; i++) begin
      valid = ($urandom_range(0, 1) == 1);
      addr  = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(64, 255)) : 8'($urandom_range(0, 63));
      cmd   = 8'($urandom);
      ack   = ($urandom_range(0, 3) == 0);
      @(negedge sys_clk);
      chk("rnd_req",  wr_req, m_req);
      chk("rnd_addr", wr_addr, m_addr);
      chk("rnd_data", wr_data, m_data);
      chk("rnd_lvl",  fifo_level, mq.size());
      chk("rnd_busy", busy, (mq.size() > 0 || m_req || m_gap > 0) ? 1 : 0);
      chk("rnd_eadr", err_addr, m_ea);
      chk("rnd_eovf", err_ovf, m_eo);
      chk("rnd_etmo", err_timeout, m_et);
      chk("rnd_ecnt", err_cnt, m_cnt);
      model_step(valid, addr, cmd, ack);
      step();
    end
    valid = 1'b0; ack = 1'b0;
    @(negedge sys_clk);
    chk("cnt_saturated", err_cnt, 255);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
